// File: rtl/hd63701_intc_pkg.sv
// Shared constants for the HD63701 peripheral interrupt controller:
// vector low bytes, line FSM state encodings and the timer priority encoder.
package hd63701_intc_pkg;

    localparam logic [7:0] vaNMI = 8'hFC;
    localparam logic [7:0] vaIRQ = 8'hF8;
    localparam logic [7:0] vaICI = 8'hF6;
    localparam logic [7:0] vaOCI = 8'hF4;
    localparam logic [7:0] vaTOI = 8'hF2;
    localparam logic [7:0] vaSCI = 8'hF0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // Timer vector nibble by fixed priority ICF > OCF > TOF; 0 when nothing pending.
    function automatic logic [3:0] timer_vec(input logic icf, input logic ocf, input logic tof);
        logic [3:0] v;
        v = 4'h0;
        if (icf)      v = vaICI[3:0];
        else if (ocf) v = vaOCI[3:0];
        else if (tof) v = vaTOI[3:0];
        return v;
    endfunction

endpackage

// File: rtl/hd63701_intc_irq_line.sv
// One edge-style request line: raise on request, drop on acknowledge or
// withdraw, and after an acknowledge stay low long enough for the
// sequencer's edge detector to see the gap before re-arming.
module hd63701_irq_line
    import hd63701_intc_pkg::*;
#(
    parameter int unsigned REARM = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    input  logic wdr,
    output logic line
);

    localparam int unsigned   CW        = (REARM > 1) ? $clog2(REARM) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(REARM - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_line;

    // Next-state logic; acknowledge takes precedence over withdraw.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req) w_next = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (ack) begin
                    w_next     = ST_HOLD;
                    w_cnt_next = HOLD_LOAD;
                end else if (wdr) begin
                    w_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) w_next = ST_IDLE;
                else             w_cnt_next = r_cnt - CW'(1);
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, hold counter and registered line output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_line  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_line  <= (w_next == ST_ASSERT);
        end
    end

    assign line = r_line;

endmodule

// File: rtl/hd63701_intc.sv
// HD63701 on-chip peripheral interrupt controller: qualifies the timer and
// SCI requests, drives IRQ2 (with vector nibble) and IRQ0 as edge-style lines,
// and recognises the CPU vector fetch as the acknowledge.
module hd63701_intc
    import hd63701_intc_pkg::*;
#(
    parameter int unsigned REARM = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ICF,
    input  logic        OCF,
    input  logic        TOF,
    input  logic        EICI,
    input  logic        EOCI,
    input  logic        ETOI,
    input  logic        SCI_REQ,
    input  logic [15:0] AD,
    input  logic        RD,
    output logic        IRQ2,
    output logic [3:0]  IRQ2V,
    output logic        IRQ0,
    output logic [3:0]  PEND
);

    logic       w_ricf;
    logic       w_rocf;
    logic       w_rtof;
    logic       w_rsci;
    logic       w_any2;
    logic [3:0] w_vec_sel;
    logic [3:0] r_vec;
    logic       w_src_req;
    logic       w_ack2;
    logic       w_ack0;
    logic       w_irq2;
    logic       w_irq0;

    assign w_ricf    = ICF & EICI;
    assign w_rocf    = OCF & EOCI;
    assign w_rtof    = TOF & ETOI;
    assign w_rsci    = SCI_REQ;
    assign PEND      = {w_ricf, w_rocf, w_rtof, w_rsci};
    assign w_any2    = w_ricf | w_rocf | w_rtof;
    assign w_vec_sel = timer_vec(w_ricf, w_rocf, w_rtof);

    // Vector latch: tracks the priority winner only while IRQ2 is low, so the
    // value captured on the rising edge is exactly the IDLE->ASSERT choice and
    // stays frozen for the whole high phase. This replaces a separate load
    // strobe from the line FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                 r_vec <= 4'h0;
        else if (!w_irq2 && w_any2) r_vec <= w_vec_sel;
    end

    // Qualified request of whichever source the latched vector names.
    always_comb begin
        w_src_req = 1'b0;
        case (r_vec)
            vaICI[3:0]: w_src_req = w_ricf;
            vaOCI[3:0]: w_src_req = w_rocf;
            vaTOI[3:0]: w_src_req = w_rtof;
            default:    w_src_req = 1'b0;
        endcase
    end

    assign w_ack2 = RD && (AD == {12'hFFF, r_vec});
    assign w_ack0 = RD && (AD == {8'hFF, vaSCI});

    hd63701_irq_line #(.REARM(REARM)) u_line_irq2 (
        .clk   (CLK),
        .rst_n (RST_N),
        .req   (w_any2),
        .ack   (w_ack2),
        .wdr   (!w_src_req),
        .line  (w_irq2)
    );

    hd63701_irq_line #(.REARM(REARM)) u_line_irq0 (
        .clk   (CLK),
        .rst_n (RST_N),
        .req   (w_rsci),
        .ack   (w_ack0),
        .wdr   (!w_rsci),
        .line  (w_irq0)
    );

    assign IRQ2  = w_irq2;
    assign IRQ0  = w_irq0;
    assign IRQ2V = r_vec;

endmodule

// File: tb/tb_hd63701_intc.sv
// Self-checking bench for hd63701_intc: a timestamp-based model of the two
// request lines checked every cycle, plus directed literal expectations.
module tb_hd63701_intc;

    localparam int unsigned REARM = 2;

    logic        CLK;
    logic        RST_N;
    logic        ICF, OCF, TOF, EICI, EOCI, ETOI, SCI_REQ;
    logic [15:0] AD;
    logic        RD;
    logic        IRQ2;
    logic [3:0]  IRQ2V;
    logic        IRQ0;
    logic [3:0]  PEND;

    int nvec = 0;
    int nmis = 0;

    hd63701_intc #(.REARM(REARM)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ICF     (ICF),
        .OCF     (OCF),
        .TOF     (TOF),
        .EICI    (EICI),
        .EOCI    (EOCI),
        .ETOI    (ETOI),
        .SCI_REQ (SCI_REQ),
        .AD      (AD),
        .RD      (RD),
        .IRQ2    (IRQ2),
        .IRQ2V   (IRQ2V),
        .IRQ0    (IRQ0),
        .PEND    (PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: each line is high or low; once low it may rise at edge number
    // >= ok. Acknowledge at edge c sets ok = c+REARM+1, withdraw sets ok = c+1.
    logic [3:0] VTAB [3] = '{4'h6, 4'h4, 4'h2};
    int         cyc   = 0;
    bit         m_hi2 = 0;
    bit         m_hi0 = 0;
    int         m_ok2 = 0;
    int         m_ok0 = 0;
    int         m_src2 = 0;
    logic [3:0] m_vec2 = 4'h0;

    initial begin
        bit q [3];
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                m_hi2  = 0;
                m_hi0  = 0;
                m_ok2  = 0;
                m_ok0  = 0;
                m_vec2 = 4'h0;
            end else begin
                cyc++;
                q[0] = ICF && EICI;
                q[1] = OCF && EOCI;
                q[2] = TOF && ETOI;
                if (m_hi2) begin
                    if (RD && AD == {12'hFFF, m_vec2}) begin
                        m_hi2 = 0;
                        m_ok2 = cyc + REARM + 1;
                    end else if (!q[m_src2]) begin
                        m_hi2 = 0;
                        m_ok2 = cyc + 1;
                    end
                end else if (cyc >= m_ok2 && (q[0] || q[1] || q[2])) begin
                    m_hi2  = 1;
                    m_src2 = q[0] ? 0 : (q[1] ? 1 : 2);
                    m_vec2 = VTAB[m_src2];
                end
                if (m_hi0) begin
                    if (RD && AD == 16'hFFF0) begin
                        m_hi0 = 0;
                        m_ok0 = cyc + REARM + 1;
                    end else if (!SCI_REQ) begin
                        m_hi0 = 0;
                        m_ok0 = cyc + 1;
                    end
                end else if (cyc >= m_ok0 && SCI_REQ) begin
                    m_hi0 = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            check("m_irq2", {15'd0, IRQ2}, {15'd0, m_hi2});
            check("m_irq0", {15'd0, IRQ0}, {15'd0, m_hi0});
            check("m_pend", {12'd0, PEND},
                  {12'd0, ICF & EICI, OCF & EOCI, TOF & ETOI, SCI_REQ});
            if (m_hi2 || !RST_N)
                check("m_irq2v", {12'd0, IRQ2V}, {12'd0, m_vec2});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        ICF = 0; OCF = 0; TOF = 0; EICI = 0; EOCI = 0; ETOI = 0; SCI_REQ = 0;
        RD = 0; AD = 16'h0000;
    endtask

    initial begin
        RST_N = 0;
        clr();
        // Reset with every source requesting
        ICF = 1; OCF = 1; TOF = 1; EICI = 1; EOCI = 1; ETOI = 1; SCI_REQ = 1;
        step(); step(); step();
        check("rst_irq2", {15'd0, IRQ2}, 16'd0);
        check("rst_irq2v", {12'd0, IRQ2V}, 16'd0);
        check("rst_irq0", {15'd0, IRQ0}, 16'd0);
        RST_N = 1;
        step();
        check("rel_irq2", {15'd0, IRQ2}, 16'd1);
        check("rel_irq0", {15'd0, IRQ0}, 16'd1);
        check("rel_irq2v", {12'd0, IRQ2V}, 16'h6);
        clr();
        step();
        check("wdr_all_irq2", {15'd0, IRQ2}, 16'd0);
        step();

        // OCF alone, vector-byte fetch ignored, real ack, 3-cycle low gap
        OCF = 1; EOCI = 1;
        step();
        check("ocf_irq2", {15'd0, IRQ2}, 16'd1);
        check("ocf_irq2v", {12'd0, IRQ2V}, 16'h4);
        check("ocf_pend", {12'd0, PEND}, 16'h4);
        RD = 1; AD = 16'hFFF5;
        step();
        check("fff5_not_ack", {15'd0, IRQ2}, 16'd1);
        AD = 16'hFFF4;
        step();
        RD = 0; AD = 16'h0000;
        check("hold_low1", {15'd0, IRQ2}, 16'd0);
        step();
        check("hold_low2", {15'd0, IRQ2}, 16'd0);
        step();
        check("hold_low3", {15'd0, IRQ2}, 16'd0);
        step();
        check("rearm_irq2", {15'd0, IRQ2}, 16'd1);
        check("rearm_irq2v", {12'd0, IRQ2V}, 16'h4);

        // Higher priority ICF arriving in ASSERT does not disturb the vector
        ICF = 1; EICI = 1;
        step();
        check("frozen_v1", {12'd0, IRQ2V}, 16'h4);
        step();
        check("frozen_v2", {12'd0, IRQ2V}, 16'h4);
        RD = 1; AD = 16'hFFF4;
        step();
        RD = 0; AD = 16'h0000;
        check("ack4_low", {15'd0, IRQ2}, 16'd0);
        step(); step();
        check("ack4_low3", {15'd0, IRQ2}, 16'd0);
        step();
        check("icf_rearm", {15'd0, IRQ2}, 16'd1);
        check("icf_rearm_v", {12'd0, IRQ2V}, 16'h6);
        clr();
        step();
        check("wdr_icf", {15'd0, IRQ2}, 16'd0);
        step();

        // Priority walk: 6 -> 4 -> 2, ack and clear in the same cycle
        ICF = 1; OCF = 1; TOF = 1; EICI = 1; EOCI = 1; ETOI = 1;
        step();
        check("prio_v6", {12'd0, IRQ2V}, 16'h6);
        RD = 1; AD = 16'hFFF6; ICF = 0;
        step();
        RD = 0;
        check("ack_wins", {15'd0, IRQ2}, 16'd0);
        step();
        check("ack_wins2", {15'd0, IRQ2}, 16'd0);
        step();
        check("ack_wins3", {15'd0, IRQ2}, 16'd0);
        step();
        check("prio_v4_line", {15'd0, IRQ2}, 16'd1);
        check("prio_v4", {12'd0, IRQ2V}, 16'h4);
        RD = 1; AD = 16'hFFF4; OCF = 0;
        step();
        RD = 0;
        step(); step(); step();
        check("prio_v2_line", {15'd0, IRQ2}, 16'd1);
        check("prio_v2", {12'd0, IRQ2V}, 16'h2);
        RD = 1; AD = 16'hFFF2; TOF = 0;
        step();
        RD = 0;
        repeat (5) step();
        check("prio_done", {15'd0, IRQ2}, 16'd0);
        clr();

        // Withdraw, then a stale vector fetch in IDLE has no effect
        TOF = 1; ETOI = 1;
        step();
        check("tof_irq2", {15'd0, IRQ2}, 16'd1);
        check("tof_irq2v", {12'd0, IRQ2V}, 16'h2);
        ETOI = 0;
        step();
        check("tof_wdr", {15'd0, IRQ2}, 16'd0);
        RD = 1; AD = 16'hFFF2;
        step();
        RD = 0; AD = 16'h0000;
        check("stale_fetch", {15'd0, IRQ2}, 16'd0);
        ETOI = 1;
        step();
        check("no_hold_after_stale", {15'd0, IRQ2}, 16'd1);
        clr();
        step(); step();

        // SCI ack leaves IRQ2 alone; async reset mid-ASSERT
        SCI_REQ = 1; OCF = 1; EOCI = 1;
        step();
        check("sci_irq0", {15'd0, IRQ0}, 16'd1);
        check("sci_irq2", {15'd0, IRQ2}, 16'd1);
        RD = 1; AD = 16'hFFF1;
        step();
        check("fff1_not_ack", {15'd0, IRQ0}, 16'd1);
        AD = 16'hFFF0;
        step();
        RD = 0; AD = 16'h0000;
        check("sci_ack_irq0", {15'd0, IRQ0}, 16'd0);
        check("sci_ack_irq2", {15'd0, IRQ2}, 16'd1);
        step(); step();
        check("sci_hold3", {15'd0, IRQ0}, 16'd0);
        step();
        check("sci_rearm", {15'd0, IRQ0}, 16'd1);
        #2 RST_N = 0;
        #1;
        check("async_irq2", {15'd0, IRQ2}, 16'd0);
        check("async_irq0", {15'd0, IRQ0}, 16'd0);
        check("async_irq2v", {12'd0, IRQ2V}, 16'd0);
        step(); step();
        clr();
        RST_N = 1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/hd63701_intc.md
# hd63701_intc

On-chip peripheral interrupt controller for the HD63701 core. It gathers the timer flags (ICF, OCF, TOF) and the SCI request and turns them into the edge-style request lines the sequencer consumes: `IRQ2` with its 4-bit low vector nibble `IRQ2V`, and `IRQ0` (SCI, vector $FFF0). The sequencer captures requests on rising edges only, so this block owns the handshake. It raises a line and holds the vector nibble stable until it sees the CPU fetch that vector. It then drops the line, and re-arms it if the source flag is still set.

## Interface
- `REARM`, default 2: number of cycles a line stays low after acknowledge before it may re-assert (minimum 1).
- `CLK` in 1: core clock; all state updates on posedge.
- `RST_N` in 1: asynchronous, active-low reset.
- `ICF`, `OCF`, `TOF` in 1 each: timer status flags (level).
- `EICI`, `EOCI`, `ETOI` in 1 each: timer interrupt enables.
- `SCI_REQ` in 1: combined SCI request level, already qualified by the SCI enables.
- `AD` in 16: CPU address bus.
- `RD` in 1: CPU read strobe, valid with `AD`.
- `IRQ2` out 1: timer request to the sequencer.
- `IRQ2V` out 4: low nibble of the timer vector: 6 = ICF, 4 = OCF, 2 = TOF.
- `IRQ0` out 1: SCI request to the sequencer.
- `PEND` out 4: {ICF, OCF, TOF, SCI} qualified requests, for status reads.

## Operation
- Qualified requests:
  - `rICF = ICF&EICI`, `rOCF = OCF&EOCI`, `rTOF = TOF&ETOI`, `rSCI = SCI_REQ`.
  - `PEND` is these four values, combinational.
- Each output line (`IRQ2`, `IRQ0`) has its own FSM with states IDLE, ASSERT, HOLD.
- IDLE, line low:
  - If any qualified request for this line is set, go to ASSERT next cycle.
  - Timer line: latch `IRQ2V` by priority ICF(6) > OCF(4) > TOF(2).
- ASSERT, line high, vector nibble frozen:
  - Acknowledge is `RD & AD=={12'hFFF, vec}` (timer) or `RD & AD==16'hFFF0` (SCI). On acknowledge, go to HOLD.
  - If the latched source's qualified request falls before acknowledge (withdraw), go to IDLE.
  - A withdraw does not cancel the edge the sequencer has already latched. A late fetch of the stale vector in IDLE is ignored.
  - A higher-priority timer source arriving in ASSERT does not change `IRQ2V`. It is taken after the next IDLE.
- HOLD, line low:
  - A counter loads `REARM-1` and decrements.
  - At zero, go to IDLE. If the request is still set, IDLE forces a fresh rising edge one cycle later.
- Acknowledge and withdraw in the same cycle: acknowledge wins (go to HOLD).
- Priority is re-evaluated only on the IDLE→ASSERT transition.
- A fetch of $FFF7/$FFF5/$FFF3/$FFF1 (vector low byte) is not an acknowledge.
- `RST_N` low, asynchronous:
  - Both FSMs go to IDLE; `IRQ2`, `IRQ0` = 0; `IRQ2V` = 4'h0; HOLD counters = 0.
  - A reset mid-ASSERT drops the line immediately.

## Timing
- Request set in cycle n → line high after posedge n+1 (one-cycle registered latency). `IRQ2V` is valid at the same edge and is held until the line falls.
- Acknowledge sampled at posedge k → line low after posedge k.
- Earliest re-assert is posedge k+REARM+1, so the minimum low time is REARM+1 cycles. This guarantees the sequencer's `pIR*` edge detector sees a 0.
- Outputs are registered; there are no combinational paths from `AD`/`RD` to `IRQ2`/`IRQ0`/`IRQ2V`.
- `PEND` is combinational from its inputs.

## Structure
- Vector constants `vaICI` = 8'hF6, `vaOCI` = 8'hF4, `vaTOI` = 8'hF2, `vaSCI` = 8'hF0 and the FSM state encodings go in `HD63701_defs.i`, next to the existing `vaNMI`/`vaIRQ`.
- Sub-module `hd63701_irq_line`:
  - Parameter `REARM`.
  - Inputs `req`, `ack`, `wdr`; output `line`; optional `load` strobe.
  - Instantiated twice.
- Top level holds the timer priority encoder, the `IRQ2V` latch, and the acknowledge address compare.

## Test plan
1. Reset: with `RST_N`=0 and all flags set → `IRQ2`=0, `IRQ2V`=0, `IRQ0`=0. Release → `IRQ2`=1 and `IRQ0`=1 one cycle later.
2. OCF=1, EOCI=1 → `IRQ2`=1, `IRQ2V`=4. Read AD=$FFF4 → `IRQ2` low for exactly 3 cycles (REARM=2), then high again while OCF stays 1.
3. OCF pending in ASSERT, then ICF+EICI set → `IRQ2V` stays 4. After ack and HOLD, re-assert with `IRQ2V`=6.
4. ICF, OCF, TOF all enabled in the same cycle → `IRQ2V`=6. Clear ICF after its ack → next edge has `IRQ2V`=4. Clear OCF after its ack → `IRQ2V`=2.
5. Withdraw: TOF=1 → `IRQ2`=1. Drop ETOI before any fetch → `IRQ2` falls next cycle. A later read of $FFF2 causes no state change.
6. Read $FFF0 while `IRQ0` is asserted and `IRQ2` pending → only `IRQ0` drops. Asserting `RST_N`=0 mid-ASSERT drops `IRQ2` asynchronously, without waiting for a clock edge.
